// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: default widths, the start address,
// the run-control state type and the program-counter type.
// No ports.
package fetch_sequencer_pkg;

    localparam int unsigned PC_W       = 10;
    localparam int unsigned START_ADDR = 0;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_RUN,
        FS_DONE
    } fetch_state_e;

    typedef logic [PC_W-1:0] pc_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer bus: branch-unit / decoder / run-control inputs and the
// instruction-ROM address plus status outputs.
//   start         run request (IDLE/DONE only)
//   branch        branch taken this cycle
//   address       branch target
//   halt_instr    current instruction is halt
//   stall         hold the PC this cycle
//   prog_counter  instruction-ROM address
//   busy          high while running
//   done          high while in DONE
//   cycle_count   RUN cycles of the current/last run
// Modports: master drives the inputs and observes status, slave is the sequencer.
interface fetch_sequencer_if #(
    parameter int unsigned PC_W  = fetch_sequencer_pkg::PC_W,
    parameter int unsigned CNT_W = fetch_sequencer_pkg::CNT_W
);

    logic             start;
    logic             branch;
    logic [PC_W-1:0]  address;
    logic             halt_instr;
    logic             stall;
    logic [PC_W-1:0]  prog_counter;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, branch, address, halt_instr, stall,
        input  prog_counter, busy, done, cycle_count
    );

    modport slave (
        input  start, branch, address, halt_instr, stall,
        output prog_counter, busy, done, cycle_count
    );

endinterface

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter used for the run cycle count.
//   clk    clock
//   reset  synchronous, active-low
//   clr    clear to zero (wins over en)
//   en     count one step; holds once all-ones is reached
//   count  registered counter value
module fetch_sequencer_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter / fetch sequencer with start/done run control.
//   clk    clock, all state on posedge
//   reset  synchronous, active-low
//   bus    fetch_sequencer_if slave: start, branch, address, halt_instr, stall in;
//          prog_counter, busy, done, cycle_count out (all registered)
// Per RUN cycle the PC source priority is halt > stall > branch > increment.
module fetch_sequencer #(
    parameter int unsigned PC_W       = fetch_sequencer_pkg::PC_W,
    parameter int unsigned START_ADDR = fetch_sequencer_pkg::START_ADDR,
    parameter int unsigned CNT_W      = fetch_sequencer_pkg::CNT_W
) (
    input logic              clk,
    input logic              reset,
    fetch_sequencer_if.slave bus
);

    import fetch_sequencer_pkg::*;

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            cnt_clr;
    logic            cnt_en;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            FS_IDLE, FS_DONE: begin
                if (bus.start) begin
                    state_d = FS_RUN;
                    pc_d    = START_PC;
                    cnt_clr = 1'b1;
                end
            end
            FS_RUN: begin
                if (bus.halt_instr) begin
                    // Halt cycle is not counted and any branch target is dropped.
                    state_d = FS_DONE;
                end else begin
                    cnt_en = 1'b1;
                    if (bus.stall) begin
                        pc_d = pc_q;
                    end else if (bus.branch) begin
                        pc_d = bus.address;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            default: begin
                state_d = FS_IDLE;
                pc_d    = START_PC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FS_IDLE;
            pc_q    <= START_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_sequencer_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (bus.cycle_count)
    );

    // Decodes of the state register only, so no input reaches an output combinationally.
    assign bus.prog_counter = pc_q;
    assign bus.busy         = (state_q == FS_RUN);
    assign bus.done         = (state_q == FS_DONE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer. Two instances share one stimulus stream:
// the default build (CNT_W=16) and a narrow-counter build (CNT_W=4) for saturation.
// A behavioural model (run state, PC, unbounded run-cycle tally) supplies every
// expected value; directed steps come first, then a randomized phase.
module tb_fetch_sequencer;

    import fetch_sequencer_pkg::*;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic clk = 1'b0;
    logic reset;
    logic start_v;
    logic branch_v;
    logic halt_v;
    logic stall_v;
    pc_t  addr_v;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.PC_W(10), .CNT_W(16)) bus ();
    fetch_sequencer_if #(.PC_W(10), .CNT_W(4))  bus4 ();

    assign bus.start       = start_v;
    assign bus.branch      = branch_v;
    assign bus.address     = addr_v;
    assign bus.halt_instr  = halt_v;
    assign bus.stall       = stall_v;
    assign bus4.start      = start_v;
    assign bus4.branch     = branch_v;
    assign bus4.address    = addr_v;
    assign bus4.halt_instr = halt_v;
    assign bus4.stall      = stall_v;

    fetch_sequencer #(
        .PC_W       (10),
        .START_ADDR (0),
        .CNT_W      (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    fetch_sequencer #(
        .PC_W       (10),
        .START_ADDR (0),
        .CNT_W      (4)
    ) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int m_st     = M_IDLE;
    int m_pc     = 0;
    int m_raw    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int raw, input int max);
        return (raw > max) ? max : raw;
    endfunction

    // Model of one clock edge using the currently applied inputs.
    task automatic model_edge();
        if (!reset) begin
            m_st  = M_IDLE;
            m_pc  = 0;
            m_raw = 0;
        end else if (m_st == M_RUN) begin
            if (halt_v) begin
                m_st = M_DONE;
            end else begin
                m_raw++;
                if (!stall_v) begin
                    m_pc = branch_v ? int'(addr_v) : (m_pc + 1) % 1024;
                end
            end
        end else if (start_v) begin
            m_st  = M_RUN;
            m_pc  = 0;
            m_raw = 0;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic b, input int a,
                        input logic h, input logic t);
        reset    = r;
        start_v  = s;
        branch_v = b;
        addr_v   = pc_t'(a);
        halt_v   = h;
        stall_v  = t;
        @(posedge clk);
        model_edge();
        #1;
        check("pc", 32'(bus.prog_counter), m_pc);
        check("busy", 32'(bus.busy), 32'(m_st == M_RUN));
        check("done", 32'(bus.done), 32'(m_st == M_DONE));
        check("count16", 32'(bus.cycle_count), sat(m_raw, 65535));
        check("count4", 32'(bus4.cycle_count), sat(m_raw, 15));
        check("pc_w4", 32'(bus4.prog_counter), m_pc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset held for two cycles.
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 55, 1, 1);
        check("rst_pc", 32'(bus.prog_counter), 0);
        check("rst_count", 32'(bus.cycle_count), 0);

        // Idle ignores run inputs.
        step(1, 0, 1, 33, 0, 0);

        // Start then five plain cycles.
        step(1, 1, 0, 0, 0, 0);
        idle(5);
        check("run_pc5", 32'(bus.prog_counter), 5);
        check("run_cnt5", 32'(bus.cycle_count), 5);

        // Branch at 7 to 98, then increment to 99; start in RUN is ignored.
        idle(2);
        step(1, 0, 1, 98, 0, 0);
        check("br_target", 32'(bus.prog_counter), 98);
        step(1, 1, 0, 0, 0, 0);
        check("br_inc", 32'(bus.prog_counter), 99);

        // Stall beats branch for two cycles at 20; stalls are counted.
        step(1, 0, 1, 20, 0, 0);
        step(1, 0, 1, 4, 0, 1);
        step(1, 0, 1, 4, 0, 1);
        check("stall_hold", 32'(bus.prog_counter), 20);
        idle(1);
        check("stall_release", 32'(bus.prog_counter), 21);

        // Halt beats branch at 179; pc and count freeze in DONE.
        step(1, 0, 1, 179, 0, 0);
        step(1, 0, 1, 5, 1, 0);
        check("halt_pc", 32'(bus.prog_counter), 179);
        check("halt_done", 32'(bus.done), 1);
        step(1, 0, 1, 9, 0, 0);
        idle(1);
        step(1, 1, 0, 0, 0, 0);
        check("restart_pc", 32'(bus.prog_counter), 0);
        check("restart_cnt", 32'(bus.cycle_count), 0);

        // PC wraps from all-ones; narrow counter saturates at 15.
        step(1, 0, 1, 1023, 0, 0);
        idle(1);
        check("wrap_pc", 32'(bus.prog_counter), 0);
        idle(20);
        check("sat4", 32'(bus4.cycle_count), 15);

        // Halt beats simultaneous start.
        step(1, 1, 0, 0, 1, 0);
        check("halt_vs_start", 32'(bus.done), 1);

        // Reset mid-run.
        step(1, 1, 0, 0, 0, 0);
        idle(3);
        step(0, 0, 1, 77, 0, 0);
        check("midrun_rst_pc", 32'(bus.prog_counter), 0);
        check("midrun_rst_busy", 32'(bus.busy), 0);

        // Randomized phase.
        for (int i = 0; i < 600; i++) begin
            step(logic'($urandom_range(59) != 0),
                 logic'($urandom_range(7) == 0),
                 logic'($urandom_range(3) == 0),
                 int'($urandom_range(1023)),
                 logic'($urandom_range(15) == 0),
                 logic'($urandom_range(4) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
